// File: rtl/vga_word_scheduler_if.sv
// rtl/vga_word_scheduler_if.sv - pattern push handshake between classifier and word scheduler
//
// Signals:
//   i_pat_valid  classifier -> scheduler, push request
//   i_pat        classifier -> scheduler, pattern number to append
//   o_pat_ready  scheduler -> classifier, push accepted when valid && ready
// Modports: master (classifier side), slave (scheduler side).
interface vga_word_scheduler_if #(
    parameter int PAT_W = 8
);
    logic             i_pat_valid;
    logic [PAT_W-1:0] i_pat;
    logic             o_pat_ready;

    modport master (
        output i_pat_valid,
        output i_pat,
        input  o_pat_ready
    );

    modport slave (
        input  i_pat_valid,
        input  i_pat,
        output o_pat_ready
    );
endinterface

// File: rtl/vga_word_scheduler.sv
// rtl/vga_word_scheduler.sv - frame-synchronous word list builder for the VGA display path
//
// Edits (push / backspace / clear) land in a shadow list; the shadow is copied to
// the committed, display-facing list only on i_frame_start while an edit is pending,
// so the picture never tears. Leaving idle issues a one-cycle display start pulse.
//
// Optional build macro: VGA_SCHED_SCROLL_EN - when the shadow is full, pushes are
// still accepted and scroll the list (oldest word dropped, new word appended).
//
// Ports:
//   i_clk          pixel clock
//   i_rst_n        synchronous active-low reset
//   i_enable       level; run the scheduler while high
//   pat_if         slave side of the pattern push handshake
//   i_clear        pulse; empty the shadow list
//   i_backspace    pulse; drop the last shadow word
//   i_frame_start  pulse at frame boundary; commit point
//   o_disp_start   one-cycle start pulse to the display
//   o_word_cnt     committed word count
//   o_pattern_num  committed patterns, entry k at [PAT_W*k +: PAT_W], unused entries 0
//   o_dirty        shadow differs from committed
//   o_full         shadow count == MAX_WORDS
module vga_word_scheduler #(
    parameter int MAX_WORDS = 31,
    parameter int PAT_W     = 8,
    parameter int CNT_W     = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_enable,
    vga_word_scheduler_if.slave   pat_if,
    input  logic                  i_clear,
    input  logic                  i_backspace,
    input  logic                  i_frame_start,
    output logic                  o_disp_start,
    output logic [CNT_W-1:0]      o_word_cnt,
    output logic [PAT_W*32-1:0]   o_pattern_num,
    output logic                  o_dirty,
    output logic                  o_full
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [PAT_W-1:0] sh  [MAX_WORDS];
    logic [PAT_W-1:0] com [MAX_WORDS];
    logic [CNT_W-1:0] sh_cnt;
    logic [CNT_W-1:0] com_cnt;
    logic             dirty;

    logic in_run;
    logic full;
    logic do_clear;
    logic do_bs;
    logic do_push;
    logic do_commit;

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_enable) state_nxt = S_ARM;
            S_ARM:   state_nxt = S_RUN;
            S_RUN:   if (!i_enable) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign in_run = (state == S_RUN);
    assign full   = (sh_cnt == CNT_W'(MAX_WORDS));

    // Output logic
    always_comb begin
        o_disp_start = (state == S_ARM);
`ifdef VGA_SCHED_SCROLL_EN
        pat_if.o_pat_ready = in_run;
`else
        pat_if.o_pat_ready = in_run && !full;
`endif
    end

    // One edit per cycle: clear beats backspace beats push. A push that loses
    // arbitration still handshakes if ready was high, and is simply dropped.
    assign do_clear  = in_run && i_clear;
    assign do_bs     = in_run && !i_clear && i_backspace && (sh_cnt != '0);
    assign do_push   = in_run && !i_clear && !i_backspace
                       && pat_if.i_pat_valid && pat_if.o_pat_ready;
    assign do_commit = in_run && i_frame_start && dirty;

`ifdef VGA_SCHED_SCROLL_EN
    // Scroll source: entry i takes entry i+1; the top entry takes the new pattern.
    logic [PAT_W-1:0] sh_up [MAX_WORDS];
    for (genvar g = 0; g < MAX_WORDS; g++) begin : g_scroll
        if (g < MAX_WORDS - 1) begin : g_mid
            assign sh_up[g] = sh[g+1];
        end else begin : g_top
            assign sh_up[g] = pat_if.i_pat;
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sh_cnt  <= '0;
            com_cnt <= '0;
            dirty   <= 1'b0;
            for (int i = 0; i < MAX_WORDS; i++) begin
                sh[i]  <= '0;
                com[i] <= '0;
            end
        end else begin
            // Commit samples the shadow before any same-cycle edit is applied.
            if (do_commit) begin
                com_cnt <= sh_cnt;
                for (int i = 0; i < MAX_WORDS; i++) begin
                    com[i] <= sh[i];
                end
            end

            if (do_clear) begin
                sh_cnt <= '0;
            end else if (do_bs) begin
                sh_cnt <= sh_cnt - 1'b1;
            end else if (do_push && !full) begin
                sh_cnt <= sh_cnt + 1'b1;
            end

            for (int i = 0; i < MAX_WORDS; i++) begin
                if (do_clear) begin
                    sh[i] <= '0;
                end else if (do_bs && (CNT_W'(i) == sh_cnt - 1'b1)) begin
                    sh[i] <= '0;
                end else if (do_push) begin
`ifdef VGA_SCHED_SCROLL_EN
                    if (full) begin
                        sh[i] <= sh_up[i];
                    end else if (CNT_W'(i) == sh_cnt) begin
                        sh[i] <= pat_if.i_pat;
                    end
`else
                    if (CNT_W'(i) == sh_cnt) begin
                        sh[i] <= pat_if.i_pat;
                    end
`endif
                end
            end

            // A same-cycle edit keeps dirty set so it commits on the next frame.
            if (do_clear || do_bs || do_push) begin
                dirty <= 1'b1;
            end else if (do_commit) begin
                dirty <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < 32; k++) begin : g_out
        if (k < MAX_WORDS) begin : g_used
            assign o_pattern_num[PAT_W*k +: PAT_W] = com[k];
        end else begin : g_unused
            assign o_pattern_num[PAT_W*k +: PAT_W] = '0;
        end
    end

    assign o_word_cnt = com_cnt;
    assign o_dirty    = dirty;
    assign o_full     = full;

endmodule

// File: tb/tb_vga_word_scheduler.sv
// tb/tb_vga_word_scheduler.sv - directed self-checking bench for vga_word_scheduler
module tb_vga_word_scheduler;

    localparam int PAT_W = 8;
    localparam int CNT_W = 5;
    localparam int MAXW  = 31;

    logic                i_clk = 1'b0;
    logic                i_rst_n;
    logic                i_enable;
    logic                i_clear;
    logic                i_backspace;
    logic                i_frame_start;
    logic                o_disp_start;
    logic [CNT_W-1:0]    o_word_cnt;
    logic [PAT_W*32-1:0] o_pattern_num;
    logic                o_dirty;
    logic                o_full;

    int vectors     = 0;
    int miscompares = 0;

    vga_word_scheduler_if #(.PAT_W(PAT_W)) pat_if ();

    vga_word_scheduler #(
        .MAX_WORDS(MAXW),
        .PAT_W    (PAT_W),
        .CNT_W    (CNT_W)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_enable     (i_enable),
        .pat_if       (pat_if.slave),
        .i_clear      (i_clear),
        .i_backspace  (i_backspace),
        .i_frame_start(i_frame_start),
        .o_disp_start (o_disp_start),
        .o_word_cnt   (o_word_cnt),
        .o_pattern_num(o_pattern_num),
        .o_dirty      (o_dirty),
        .o_full       (o_full)
    );

    always #5 i_clk = ~i_clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push(input logic [PAT_W-1:0] v);
        pat_if.i_pat_valid = 1'b1;
        pat_if.i_pat       = v;
        tick();
        pat_if.i_pat_valid = 1'b0;
    endtask

    task automatic frame();
        i_frame_start = 1'b1;
        tick();
        i_frame_start = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n            = 1'b0;
        i_enable           = 1'b0;
        i_clear            = 1'b0;
        i_backspace        = 1'b0;
        i_frame_start      = 1'b0;
        pat_if.i_pat_valid = 1'b0;
        pat_if.i_pat       = '0;
        tick();
        tick();
        i_rst_n = 1'b1;
        tick();
        vectors++;
        if (o_word_cnt !== 5'd0 || o_pattern_num !== '0) begin
            miscompares++;
            $display("FAIL reset_lists cnt=%0d pat=%h want 0/0", o_word_cnt, o_pattern_num);
        end
        vectors++;
        if ({pat_if.o_pat_ready, o_disp_start, o_dirty, o_full} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags rdy/start/dirty/full=%b want 0000",
                     {pat_if.o_pat_ready, o_disp_start, o_dirty, o_full});
        end
    endtask

    task automatic test_start();
        i_enable = 1'b1;
        vectors++;
        if (o_disp_start !== 1'b0) begin
            miscompares++;
            $display("FAIL start_pre disp_start=%b want 0", o_disp_start);
        end
        tick();
        vectors++;
        if (o_disp_start !== 1'b1 || pat_if.o_pat_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL start_arm start=%b rdy=%b want 1/0", o_disp_start, pat_if.o_pat_ready);
        end
        tick();
        vectors++;
        if (o_disp_start !== 1'b0 || pat_if.o_pat_ready !== 1'b1 || o_word_cnt !== 5'd0) begin
            miscompares++;
            $display("FAIL start_run start=%b rdy=%b cnt=%0d want 0/1/0",
                     o_disp_start, pat_if.o_pat_ready, o_word_cnt);
        end
    endtask

    task automatic test_push_commit();
        push(8'd2);
        push(8'd3);
        vectors++;
        if (o_word_cnt !== 5'd0 || o_dirty !== 1'b1) begin
            miscompares++;
            $display("FAIL precommit cnt=%0d dirty=%b want 0/1", o_word_cnt, o_dirty);
        end
        frame();
        vectors++;
        if (o_word_cnt !== 5'd2 || o_pattern_num[15:0] !== 16'h0302 || o_dirty !== 1'b0) begin
            miscompares++;
            $display("FAIL commit_23 cnt=%0d e10=%h dirty=%b want 2/0302/0",
                     o_word_cnt, o_pattern_num[15:0], o_dirty);
        end
    endtask

    task automatic test_commit_with_edit();
        // Re-dirty the shadow while keeping it at {2,3}.
        push(8'd7);
        i_backspace = 1'b1;
        tick();
        i_backspace = 1'b0;
        pat_if.i_pat_valid = 1'b1;
        pat_if.i_pat       = 8'd5;
        i_frame_start      = 1'b1;
        tick();
        pat_if.i_pat_valid = 1'b0;
        i_frame_start      = 1'b0;
        vectors++;
        if (o_word_cnt !== 5'd2 || o_pattern_num[23:0] !== 24'h000302 || o_dirty !== 1'b1) begin
            miscompares++;
            $display("FAIL commit_edit cnt=%0d e=%h dirty=%b want 2/000302/1",
                     o_word_cnt, o_pattern_num[23:0], o_dirty);
        end
        frame();
        vectors++;
        if (o_word_cnt !== 5'd3 || o_pattern_num[23:0] !== 24'h050302 || o_dirty !== 1'b0) begin
            miscompares++;
            $display("FAIL commit_235 cnt=%0d e=%h dirty=%b want 3/050302/0",
                     o_word_cnt, o_pattern_num[23:0], o_dirty);
        end
    endtask

    task automatic test_priority();
        i_clear            = 1'b1;
        i_backspace        = 1'b1;
        pat_if.i_pat_valid = 1'b1;
        pat_if.i_pat       = 8'd9;
        vectors++;
        if (pat_if.o_pat_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL prio_ready rdy=%b want 1", pat_if.o_pat_ready);
        end
        tick();
        i_clear            = 1'b0;
        i_backspace        = 1'b0;
        pat_if.i_pat_valid = 1'b0;
        frame();
        vectors++;
        if (o_word_cnt !== 5'd0 || o_pattern_num !== '0 || o_dirty !== 1'b0) begin
            miscompares++;
            $display("FAIL prio_clear cnt=%0d pat=%h dirty=%b want 0/0/0",
                     o_word_cnt, o_pattern_num, o_dirty);
        end
    endtask

    task automatic test_backspace_empty();
        i_backspace = 1'b1;
        tick();
        i_backspace = 1'b0;
        vectors++;
        if (o_dirty !== 1'b0) begin
            miscompares++;
            $display("FAIL bs_empty_dirty dirty=%b want 0", o_dirty);
        end
        frame();
        vectors++;
        if (o_word_cnt !== 5'd0 || o_dirty !== 1'b0 || o_pattern_num !== '0) begin
            miscompares++;
            $display("FAIL bs_empty_frame cnt=%0d dirty=%b want 0/0", o_word_cnt, o_dirty);
        end
    endtask

    task automatic test_full();
        logic [PAT_W-1:0] exp_e;
        int bad;
        for (int v = 1; v <= MAXW; v++) push(PAT_W'(v));
        vectors++;
        if (o_full !== 1'b1) begin
            miscompares++;
            $display("FAIL full_flag full=%b want 1", o_full);
        end
`ifdef VGA_SCHED_SCROLL_EN
        vectors++;
        if (pat_if.o_pat_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL full_ready rdy=%b want 1", pat_if.o_pat_ready);
        end
`else
        vectors++;
        if (pat_if.o_pat_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full_ready rdy=%b want 0", pat_if.o_pat_ready);
        end
`endif
        push(8'd99);
        frame();
        vectors++;
        if (o_word_cnt !== 5'd31 || o_full !== 1'b1) begin
            miscompares++;
            $display("FAIL full_cnt cnt=%0d full=%b want 31/1", o_word_cnt, o_full);
        end
        bad = 0;
        for (int k = 0; k < 32; k++) begin
`ifdef VGA_SCHED_SCROLL_EN
            exp_e = (k < 30) ? PAT_W'(k + 2) : ((k == 30) ? 8'd99 : 8'd0);
`else
            exp_e = (k < 31) ? PAT_W'(k + 1) : 8'd0;
`endif
            if (o_pattern_num[PAT_W*k +: PAT_W] !== exp_e && bad == 0) begin
                bad = 1;
                $display("FAIL full_list entry%0d=%0d want %0d", k,
                         o_pattern_num[PAT_W*k +: PAT_W], exp_e);
            end
        end
        vectors++;
        miscompares += bad;
    endtask

    task automatic test_disable();
        i_enable = 1'b0;
        tick();
        vectors++;
        if (pat_if.o_pat_ready !== 1'b0 || o_word_cnt !== 5'd31) begin
            miscompares++;
            $display("FAIL disable rdy=%b cnt=%0d want 0/31", pat_if.o_pat_ready, o_word_cnt);
        end
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        vectors++;
        if (o_dirty !== 1'b0 || o_full !== 1'b1) begin
            miscompares++;
            $display("FAIL idle_ignore dirty=%b full=%b want 0/1", o_dirty, o_full);
        end
        i_enable = 1'b1;
        tick();
        vectors++;
        if (o_disp_start !== 1'b1) begin
            miscompares++;
            $display("FAIL restart disp_start=%b want 1", o_disp_start);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_push_commit();
        test_commit_with_edit();
        test_priority();
        test_backspace_empty();
        test_full();
        test_disable();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
